l_1_1: RTL and testbench

L_1_1 -- requirements
Module: l_1_1

---
 rtl/l_1_1.sv | 76 +++++++
 tb/tb_l_1_1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/l_1_1.sv
// l_1_1: 1-bit magnitude comparator with per-relation saturating cycle counters.
//
// Ports:
//   clk     - rising-edge clock for all sequential logic
//   rst     - synchronous active-high reset
//   A, B    - unsigned 1-bit compare operands
//   o1      - less-than flag (A < B)
//   o2      - equal flag (A == B)
//   o3      - greater-than flag (A > B)
//   lt_cnt  - saturating count of edges that sampled A < B
//   eq_cnt  - saturating count of edges that sampled A == B
//   gt_cnt  - saturating count of edges that sampled A > B
//
// Build option:
//   L_1_1_COMB_OUT_EN - when defined, o1/o2/o3 are driven combinationally
//                       from A/B (zero latency, independent of clk and rst).
//                       Counters stay clocked and reset either way.
module l_1_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic [7:0] lt_cnt,
    output logic [7:0] eq_cnt,
    output logic [7:0] gt_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Compare relations; exactly one is high for any A/B.
    logic lt_c;
    logic eq_c;
    logic gt_c;

    assign lt_c = ~A & B;
    assign eq_c = ~(A ^ B);
    assign gt_c = A & ~B;

    // Saturating counters: a full counter holds, the others keep counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else begin
            if (lt_c && (lt_cnt != CNT_MAX)) lt_cnt <= lt_cnt + CNT_W'(1);
            if (eq_c && (eq_cnt != CNT_MAX)) eq_cnt <= eq_cnt + CNT_W'(1);
            if (gt_c && (gt_cnt != CNT_MAX)) gt_cnt <= gt_cnt + CNT_W'(1);
        end
    end

`ifdef L_1_1_COMB_OUT_EN
    // Zero-latency flags.
    assign o1 = lt_c;
    assign o2 = eq_c;
    assign o3 = gt_c;
`else
    // Flags reflect A/B sampled at the previous edge; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o1 <= 1'b0;
            o2 <= 1'b0;
            o3 <= 1'b0;
        end else begin
            o1 <= lt_c;
            o2 <= eq_c;
            o3 <= gt_c;
        end
    end
`endif

endmodule

// File: tb/tb_l_1_1.sv
// Scoreboard bench for l_1_1: a reference model pushes the expected post-edge
// state when each cycle's stimulus is driven; it is popped and compared after
// the edge, and again after the operands are disturbed between edges.
module tb_l_1_1;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       o1;
    logic       o2;
    logic       o3;
    logic [7:0] lt_cnt;
    logic [7:0] eq_cnt;
    logic [7:0] gt_cnt;

    typedef struct packed {
        logic       o1;
        logic       o2;
        logic       o3;
        logic [7:0] lt;
        logic [7:0] eq;
        logic [7:0] gt;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state.
    logic [7:0] m_lt = 8'h00;
    logic [7:0] m_eq = 8'h00;
    logic [7:0] m_gt = 8'h00;

    l_1_1 dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a),
        .B      (b),
        .o1     (o1),
        .o2     (o2),
        .o3     (o3),
        .lt_cnt (lt_cnt),
        .eq_cnt (eq_cnt),
        .gt_cnt (gt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".o1"}, 8'(o1), 8'(e.o1));
        check({tag, ".o2"}, 8'(o2), 8'(e.o2));
        check({tag, ".o3"}, 8'(o3), 8'(e.o3));
        check({tag, ".lt"}, lt_cnt, e.lt);
        check({tag, ".eq"}, eq_cnt, e.eq);
        check({tag, ".gt"}, gt_cnt, e.gt);
    endtask

    // One clock cycle: drive operands/reset, model the edge, then check.
    task automatic step(input string tag, input logic av, input logic bv, input logic rv);
        exp_t e;
        exp_t got;
        a   = av;
        b   = bv;
        rst = rv;
        if (rv) begin
            m_lt = 8'h00;
            m_eq = 8'h00;
            m_gt = 8'h00;
        end else begin
            if (!av && bv)  m_lt = sat_inc(m_lt);
            if (av == bv)   m_eq = sat_inc(m_eq);
            if (av && !bv)  m_gt = sat_inc(m_gt);
        end
`ifdef L_1_1_COMB_OUT_EN
        e.o1 = !av && bv;
        e.o2 = av == bv;
        e.o3 = av && !bv;
`else
        e.o1 = !rv && !av && bv;
        e.o2 = !rv && (av == bv);
        e.o3 = !rv && av && !bv;
`endif
        e.lt = m_lt;
        e.eq = m_eq;
        e.gt = m_gt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            got = exp_q.pop_front();
            compare_all(tag, got);
`ifndef L_1_1_COMB_OUT_EN
            // Operand changes between edges must not disturb registered state.
            a = ~av;
            b = bv;
            #2;
            compare_all({tag, ".hold"}, got);
`endif
        end
    endtask

    initial begin
        a   = 1'b0;
        b   = 1'b0;
        rst = 1'b1;

        // Reset for two edges.
        step("rst0", 1'b0, 1'b0, 1'b1);
        step("rst1", 1'b1, 1'b0, 1'b1);

        // Truth table.
        step("tt00", 1'b0, 1'b0, 1'b0);
        step("tt01", 1'b0, 1'b1, 1'b0);
        step("tt10", 1'b1, 1'b0, 1'b0);
        step("tt11", 1'b1, 1'b1, 1'b0);

`ifdef L_1_1_COMB_OUT_EN
        // Same-step combinational response.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            a  = ab[1];
            b  = ab[0];
            #1;
            check("comb.o1", 8'(o1), 8'(!ab[1] && ab[0]));
            check("comb.o2", 8'(o2), 8'(ab[1] == ab[0]));
            check("comb.o3", 8'(o3), 8'(ab[1] && !ab[0]));
        end
`endif

        // Counting: 5 x A>B then 3 x A==B from a clean reset.
        step("cnt_rst", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("cnt_gt", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("cnt_eq", 1'b1, 1'b1, 1'b0);
        check("cnt_total.gt", gt_cnt, 8'd5);
        check("cnt_total.eq", eq_cnt, 8'd3);
        check("cnt_total.lt", lt_cnt, 8'd0);

        // Mid-run reset after 10 random counting edges, then resume from 1.
        for (int i = 0; i < 10; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(0, 3));
            step("mid_run", r[1], r[0], 1'b0);
        end
        step("mid_rst", 1'b0, 1'b1, 1'b1);
        step("mid_resume", 1'b0, 1'b1, 1'b0);
        check("mid_resume.lt1", lt_cnt, 8'd1);

        // Saturation: 300 edges of A<B.
        step("sat_rst", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step("sat_lt", 1'b0, 1'b1, 1'b0);
        check("sat.lt_ff", lt_cnt, 8'hFF);
        check("sat.eq0", eq_cnt, 8'd0);
        check("sat.gt0", gt_cnt, 8'd0);

        // Saturated counter holds while the others keep counting.
        step("sat_gt", 1'b1, 1'b0, 1'b0);
        step("sat_eq", 1'b0, 1'b0, 1'b0);
        step("sat_lt_hold", 1'b0, 1'b1, 1'b0);
        check("sat_after.lt", lt_cnt, 8'hFF);
        check("sat_after.gt", gt_cnt, 8'd1);
        check("sat_after.eq", eq_cnt, 8'd1);

        // Random tail.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 7));
            step("rand", r[1], r[0], (r == 3'd7));
        end

        check("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
